twos_serial_ctrl: RTL and testbench

//  Bit-serial two's-complement sequencer: latches a WIDTH-bit operand on start,

---
 rtl/twos_serial_ctrl.sv | 123 ++++++++++++
 tb/tb_twos_serial_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/twos_serial_ctrl.sv
// Bit-serial two's-complement negator: LSB-first walk, copy through the first 1, invert above.
// Optional macro TWOS_ABS_EN adds abs_en: non-negative operands pass through unchanged.
module twos_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
`ifdef TWOS_ABS_EN
  input  logic             abs_en,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] sreg_q, sreg_nxt;
  logic [WIDTH-1:0] res_q, res_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             seen_q, seen_nxt;
  logic             keep_q, keep_nxt;
  logic             ovf_p_q, ovf_p_nxt;
  logic             zero_p_q, zero_p_nxt;
  logic             done_nxt, ovf_nxt, zero_nxt;
  logic             out_bit;
  logic             keep_req;

`ifdef TWOS_ABS_EN
  assign keep_req = abs_en & ~din[WIDTH-1];
`else
  assign keep_req = 1'b0;
`endif

  assign busy = (state_q == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      keep_q   <= 1'b0;
      ovf_p_q  <= 1'b0;
      zero_p_q <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      sreg_q   <= sreg_nxt;
      res_q    <= res_nxt;
      cnt_q    <= cnt_nxt;
      seen_q   <= seen_nxt;
      keep_q   <= keep_nxt;
      ovf_p_q  <= ovf_p_nxt;
      zero_p_q <= zero_p_nxt;
      done     <= done_nxt;
      dout     <= dout_nxt;
      ovf      <= ovf_nxt;
      zero     <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    sreg_nxt   = sreg_q;
    res_nxt    = res_q;
    cnt_nxt    = cnt_q;
    seen_nxt   = seen_q;
    keep_nxt   = keep_q;
    ovf_p_nxt  = ovf_p_q;
    zero_p_nxt = zero_p_q;
    done_nxt   = 1'b0;
    dout_nxt   = dout;
    ovf_nxt    = ovf;
    zero_nxt   = zero;
    out_bit    = keep_q ? sreg_q[0] : (sreg_q[0] ^ seen_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt  = SHIFT;
          sreg_nxt   = din;
          cnt_nxt    = '0;
          seen_nxt   = 1'b0;
          keep_nxt   = keep_req;
          ovf_p_nxt  = (din == MIN_NEG);
          zero_p_nxt = (din == '0);
        end
      end
      SHIFT: begin
        sreg_nxt = sreg_q >> 1;
        res_nxt  = {out_bit, res_q[WIDTH-1:1]};
        seen_nxt = seen_q | sreg_q[0];
        if (cnt_q == LAST) begin
          // completion: publish result and flags together
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          dout_nxt  = {out_bit, res_q[WIDTH-1:1]};
          ovf_nxt   = ovf_p_q;
          zero_nxt  = zero_p_q;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_twos_serial_ctrl.sv
// Directed bench for twos_serial_ctrl (WIDTH=8); abs_en steps run when TWOS_ABS_EN is defined.
module tb_twos_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       abs_en = 1'b0;
  logic       busy, done, ovf, zero;
  logic [7:0] dout;
  int         checks = 0;
  int         failures = 0;

  twos_serial_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
`ifdef TWOS_ABS_EN
    .abs_en(abs_en),
`endif
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // accept on one edge, then count edges until done (bounded)
  task automatic run_op(input string tag, input logic [7:0] d, input logic [7:0] e,
                        input logic eo, input logic ez);
    int lat;
    @(negedge clk);
    start = 1'b1;
    din   = d;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},  lat, 32'd8);
    check({tag, "_dout"}, {24'd0, dout}, {24'd0, e});
    check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    @(posedge clk); #1;
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    int done_at;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_dout", {24'd0, dout}, 32'd0);
    check("idle_ovf",  {31'd0, ovf},  32'd0);
    check("idle_zero", {31'd0, zero}, 32'd0);

    // 2./3. basic negations and corner operands
    run_op("op0c", 8'h0C, 8'hF4, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_dout", {24'd0, dout}, 32'h0000_00F4);
    run_op("op01", 8'h01, 8'hFF, 1'b0, 1'b0);
    run_op("op80", 8'h80, 8'h80, 1'b1, 1'b0);
    run_op("op00", 8'h00, 8'h00, 1'b0, 1'b1);
    run_op("opa6", 8'hA6, 8'h5A, 1'b0, 1'b0);

    // 4. start held, din changed mid-op, back-to-back accept in done cycle
    @(negedge clk);
    start = 1'b1;
    din   = 8'h33;
    @(posedge clk); #1;
    check("b2b_busy0", {31'd0, busy}, 32'd1);
    pulses  = 0;
    done_at = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 3) din = 8'h05;
      if (done) begin
        pulses++;
        done_at = i;
      end
    end
    check("b2b_pulses", pulses, 32'd1);
    check("b2b_done_at", done_at, 32'd8);
    check("b2b_dout0", {24'd0, dout}, 32'h0000_00CD);
    check("b2b_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy1", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat1", lat, 32'd8);
    check("b2b_dout1", {24'd0, dout}, 32'h0000_00FB);

    // 5. reset mid-operation
    @(negedge clk);
    start = 1'b1;
    din   = 8'h0C;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_dout", {24'd0, dout}, 32'd0);
    check("mrst_ovf",  {31'd0, ovf},  32'd0);
    check("mrst_zero", {31'd0, zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("mrst_no_done", pulses, 32'd0);
    run_op("after_rst", 8'h0C, 8'hF4, 1'b0, 1'b0);

`ifdef TWOS_ABS_EN
    // 6. absolute-value mode
    abs_en = 1'b1;
    run_op("abs05", 8'h05, 8'h05, 1'b0, 1'b0);
    run_op("absfb", 8'hFB, 8'h05, 1'b0, 1'b0);
    run_op("abs80", 8'h80, 8'h80, 1'b1, 1'b0);
    abs_en = 1'b0;
    run_op("noabs05", 8'h05, 8'hFB, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
